// File: rtl/seq_shift_unit_pkg.sv
// Shared constants and types for the sequential shift/rotate unit.
package seq_shift_unit_pkg;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned AMT_W = 3;

    localparam logic [1:0] MODE_LOGIC = 2'b00;
    localparam logic [1:0] MODE_ARITH = 2'b01;
    localparam logic [1:0] MODE_ROT   = 2'b10;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

endpackage

// File: rtl/seq_shift_unit_if.sv
// Start/busy/done handshake plus operand and result lines of the shift unit.
interface seq_shift_unit_if;
    import seq_shift_unit_pkg::*;

    logic             start;
    logic [WIDTH-1:0] d;
    logic [AMT_W-1:0] amount;
    logic             control;
    logic [1:0]       mode;
    logic [WIDTH-1:0] q;
    logic             carry;
    logic             busy;
    logic             done;

    modport master (
        output start, d, amount, control, mode,
        input  q, carry, busy, done
    );

    modport slave (
        input  start, d, amount, control, mode,
        output q, carry, busy, done
    );

endinterface

// File: rtl/seq_shift_unit_shift_step.sv
// One single-bit shift/rotate step; out_bit is the bit leaving (or wrapping) the word.
module shift_step
    import seq_shift_unit_pkg::*;
(
    input  logic [WIDTH-1:0] q,
    input  logic             control,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] q_next,
    output logic             out_bit
);

    always_comb begin
        q_next  = q;
        out_bit = 1'b0;
        if (control == DIR_LEFT) begin
            out_bit = q[WIDTH-1];
            // Arithmetic left is the same as logical left.
            if (mode == MODE_ROT) q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            else                  q_next = {q[WIDTH-2:0], 1'b0};
        end else begin
            out_bit = q[0];
            case (mode)
                MODE_ROT:   q_next = {q[0], q[WIDTH-1:1]};
                MODE_ARITH: q_next = {q[WIDTH-1], q[WIDTH-1:1]};
                default:    q_next = {1'b0, q[WIDTH-1:1]};
            endcase
        end
    end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle 8-bit shift/rotate unit: one bit per clock, start/busy/done handshake.
module seq_shift_unit
    import seq_shift_unit_pkg::*;
#(
    parameter int unsigned n = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    seq_shift_unit_if.slave  bus
);

    state_e           state_q, state_d;
    logic [n-1:0]     result_q, result_d;
    logic             carry_q, carry_d;
    logic [AMT_W-1:0] count_q, count_d;
    logic             control_q, control_d;
    logic [1:0]       mode_q, mode_d;

    logic [n-1:0]     step_q;
    logic             step_bit;

    shift_step u_step (
        .q       (result_q),
        .control (control_q),
        .mode    (mode_q),
        .q_next  (step_q),
        .out_bit (step_bit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            result_q  <= '0;
            carry_q   <= 1'b0;
            count_q   <= '0;
            control_q <= DIR_LEFT;
            mode_q    <= MODE_LOGIC;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            carry_q   <= carry_d;
            count_q   <= count_d;
            control_q <= control_d;
            mode_q    <= mode_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        carry_d   = carry_q;
        count_d   = count_q;
        control_d = control_q;
        mode_d    = mode_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    result_d  = bus.d;
                    carry_d   = 1'b0;
                    count_d   = bus.amount;
                    control_d = bus.control;
                    mode_d    = bus.mode;
                    state_d   = (bus.amount != '0) ? StShift : StDone;
                end
            end
            StShift: begin
                result_d = step_q;
                carry_d  = step_bit;
                count_d  = count_q - AMT_W'(1);
                if (count_q == AMT_W'(1)) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decode straight from flops; nothing combinational from the inputs.
    assign bus.q     = result_q;
    assign bus.carry = carry_q;
    assign bus.busy  = (state_q != StIdle);
    assign bus.done  = (state_q == StDone);

endmodule
